// File: rtl/mio_uart_tx.sv
// ---------------------------------------------------------------------------
// mio_uart_tx
// Memory-mapped UART transmitter on the MIO bus. The CPU pushes bytes into a
// small TX FIFO. A bit-timer driven FSM sends each byte as an 8N1 frame on
// txd, LSB first. Each bit lasts div clock cycles, so a frame lasts 10*div
// cycles. Consecutive frames are sent with no idle gap between them.
//
// Register map (word offset on addr):
//   0 DATA   W: push wdata[7:0] into the FIFO            R: 0
//   1 STATUS R: [0] busy [1] full [2] empty [3] overflow (sticky) [8:4] count
//            W: wdata[3]=1 clears overflow
//   2 CTRL   R/W: [0] en [1] irq_en
//   3 BAUD   R/W: [15:0] div (bit period in clk cycles; values <2 act as 2)
//
// Ports:
//   clk    system clock, rising edge
//   rstn   asynchronous active-low reset
//   sel    chip select from the MIO address decoder
//   we     write strobe, qualified by sel
//   addr   register word offset (CPU address bits [3:2])
//   wdata  CPU write data
//   rdata  read data; combinational from addr while sel=1, else 0
//   txd    serial output, idle high
//   irq    level interrupt: all queued data sent (irq_en & empty & ~busy)
// ---------------------------------------------------------------------------
module mio_uart_tx #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Control / status registers
  logic        en;
  logic        irq_en;
  logic [15:0] div;
  logic        overflow;

  // TX FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  // Serialiser
  state_t      state;
  logic [7:0]  shift;
  logic [15:0] bit_timer;
  logic [15:0] cur_div;
  logic [2:0]  bit_idx;

  // Decode and handshake signals
  logic        wr_en;
  logic        push;
  logic        pop;
  logic        push_ok;
  logic        empty;
  logic        full;
  logic        busy;
  logic        bit_end;
  logic [15:0] div_eff;
  logic [7:0]  head;
  logic [4:0]  count_ext;

  // Only the low half of the bus carries register fields.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^wdata[31:16];

  // NOTE: every signal assigned in an always_comb block gets a default
  // value first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_en     = sel & we;
    push      = wr_en & (addr == REG_DATA);
    empty     = (count == '0);
    full      = (count == CNT_W'(FIFO_DEPTH));
    busy      = (state != ST_IDLE);
    bit_end   = (bit_timer == 16'd0);
    div_eff   = (div < 16'd2) ? 16'd2 : div;
    head      = mem[rptr];
    count_ext = 5'(count);
    // A new frame is loaded from IDLE, or straight from the last stop-bit
    // cycle, which gives back-to-back frames.
    pop       = en & ~empty &
                ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
    // A push into a full FIFO is accepted when a pop frees a slot on the
    // same edge.
    push_ok   = push & (~full | pop);
  end

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the edge no matter how blocks are ordered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      div      <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_en && addr == REG_CTRL) begin
        en     <= wdata[0];
        irq_en <= wdata[1];
      end
      if (wr_en && addr == REG_BAUD) begin
        div <= wdata[15:0];
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (wr_en && addr == REG_STATUS && wdata[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  // NOTE: the data array has no reset. Reset clears the pointers and the
  // count, which makes stale contents unreachable, so the array can map
  // onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Serialiser FSM. txd is registered, so it changes on the edge after the
  // one on which the state is decided. The bit timer counts from cur_div-1
  // down to 0, and 0 ends the bit. cur_div is captured at frame load, so a
  // BAUD write during a frame takes effect only from the next frame.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      txd       <= 1'b1;
      shift     <= 8'h00;
      bit_timer <= 16'd0;
      cur_div   <= 16'd2;
      bit_idx   <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift     <= head;
            cur_div   <= div_eff;
            bit_timer <= div_eff - 16'd1;
            txd       <= 1'b0;
            state     <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            bit_idx   <= 3'd0;
            txd       <= shift[0];
            bit_timer <= cur_div - 16'd1;
            state     <= ST_DATA;
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            bit_timer <= cur_div - 16'd1;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[bit_idx + 3'd1];
            end
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift     <= head;
              cur_div   <= div_eff;
              bit_timer <= div_eff - 16'd1;
              txd       <= 1'b0;
              state     <= ST_START;
            end else begin
              txd   <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end

        default: begin
          txd   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Interrupt: registered, so irq follows its condition by one cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & empty & ~busy;
    end
  end

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (addr)
        REG_STATUS: rdata = {23'h0, count_ext, overflow, empty, full, busy};
        REG_CTRL:   rdata = {30'h0, irq_en, en};
        REG_BAUD:   rdata = {16'h0, div};
        default:    rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mio_uart_tx
// Self-checking bench for mio_uart_tx (FIFO_DEPTH=4). A txd monitor decodes
// every frame at the divisor currently in force. It checks that each bit is
// held for exactly div cycles, and compares the decoded byte with a
// scoreboard queue that is filled as bytes are written.
// ---------------------------------------------------------------------------
module tb_mio_uart_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        txd;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [$];      // bytes expected on txd, in order
  int         mon_div = 868;
  int         frames_done = 0;

  mio_uart_tx #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd868)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .txd   (txd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    we  = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    @(negedge clk);
    d   = rdata;
    sel = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frames_done", frames_done, n);
  endtask

  // txd monitor: sample on every falling clock edge; a low txd out of reset
  // starts a frame.
  initial begin : monitor
    int         d;
    logic [9:0] bits;
    logic       stable;
    logic       aborted;
    logic [7:0] exp_byte;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && txd === 1'b0) begin
        d       = mon_div;
        bits    = '0;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < d; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (rstn !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (c == 0) bits[b] = txd;
            else if (txd !== bits[b]) stable = 1'b0;
          end
        end
        if (!aborted) begin
          check("bit_hold_stable", stable, 1);
          check("start_bit", bits[0], 0);
          check("stop_bit", bits[9], 1);
          if (sb.size() == 0) begin
            check("sb_frame_expected", sb.size(), 1);
          end else begin
            exp_byte = sb.pop_front();
            check("frame_byte", bits[8:1], exp_byte);
          end
          frames_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] r;
    int          busy_cnt;
    int          runs;
    int          fall_idx;
    int          irq_idx;
    logic        prev_busy;
    logic [7:0]  fill [4];

    rstn  = 1'b0;
    sel   = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("txd_in_reset", txd, 1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // ---- reset state ----
    check("rdata_sel_low", rdata, 0);
    bus_read(2'd1, r); check("reset_status", r, 32'h004);
    bus_read(2'd2, r); check("reset_ctrl", r, 32'h0);
    bus_read(2'd3, r); check("reset_baud", r, 32'd868);
    bus_read(2'd0, r); check("data_reads_zero", r, 32'h0);
    check("reset_txd", txd, 1);
    check("reset_irq", irq, 0);

    // ---- single frame 0xA5 at div=4 ----
    mon_div = 4;
    bus_write(2'd3, 32'd4);
    bus_write(2'd2, 32'h1);
    sb.push_back(8'hA5);
    bus_write(2'd0, 32'hA5);
    busy_cnt = 0;
    repeat (60) begin
      bus_read(2'd1, r);
      busy_cnt += int'(r[0]);
    end
    check("busy_cycles_div4", busy_cnt, 40);
    wait_frames(1, 100);

    // ---- overflow with en=0 ----
    bus_write(2'd2, 32'h0);
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (fill[i]) begin
      sb.push_back(fill[i]);
      bus_write(2'd0, {24'h0, fill[i]});
    end
    bus_write(2'd0, 32'h55);          // FIFO full: dropped
    bus_read(2'd1, r); check("status_full_ovf", r, 32'h04A);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, r); check("status_ovf_cleared", r, 32'h042);

    // ---- back-to-back frames at div=2 and the irq ----
    mon_div = 2;
    bus_write(2'd3, 32'd2);
    bus_write(2'd2, 32'h3);
    busy_cnt  = 0;
    runs      = 0;
    fall_idx  = -1;
    irq_idx   = -1;
    prev_busy = 1'b0;
    for (int i = 0; i < 120; i++) begin
      bus_read(2'd1, r);
      if (r[0]) busy_cnt++;
      if (prev_busy && !r[0]) begin
        runs++;
        if (fall_idx < 0) fall_idx = i;
      end
      if (irq === 1'b1 && irq_idx < 0) irq_idx = i;
      prev_busy = r[0];
    end
    check("busy_cycles_4frames", busy_cnt, 80);
    check("busy_single_run", runs, 1);
    check("irq_one_cycle_after_idle", irq_idx, fall_idx + 1);
    wait_frames(5, 50);
    bus_write(2'd2, 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("irq_dropped", irq, 0);

    // ---- push into a full FIFO on the same edge as the frame pop ----
    bus_write(2'd2, 32'h0);
    fill = '{8'h61, 8'h62, 8'h63, 8'h64};
    foreach (fill[i]) begin
      sb.push_back(fill[i]);
      bus_write(2'd0, {24'h0, fill[i]});
    end
    bus_write(2'd2, 32'h1);           // pop happens on the next edge
    sb.push_back(8'h65);
    bus_write(2'd0, 32'h65);          // coincides with that pop
    bus_read(2'd1, r); check("status_push_pop_full", r, 32'h043);
    wait_frames(10, 200);

    // ---- BAUD change and disable mid-frame ----
    bus_write(2'd2, 32'h0);
    mon_div = 4;
    bus_write(2'd3, 32'd4);
    sb.push_back(8'h3C);
    bus_write(2'd0, 32'h3C);
    bus_write(2'd0, 32'hC3);          // stays queued
    bus_write(2'd2, 32'h1);
    repeat (10) @(negedge clk);
    bus_write(2'd3, 32'd8);
    mon_div = 8;
    bus_write(2'd2, 32'h0);
    wait_frames(11, 80);
    repeat (40) @(negedge clk);
    check("no_frame_after_disable", frames_done, 11);
    check("txd_idle_after_disable", txd, 1);
    bus_read(2'd1, r); check("status_retained", r, 32'h010);
    bus_read(2'd3, r); check("baud_readback", r, 32'd8);

    // ---- reset mid-frame ----
    bus_write(2'd2, 32'h1);
    repeat (20) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("txd_async_reset", txd, 1);
    sb.delete();
    bus_read(2'd1, r); check("status_flushed", r, 32'h004);
    check("irq_in_reset", irq, 0);
    rstn = 1'b1;
    bus_read(2'd2, r); check("ctrl_after_reset", r, 32'h0);
    bus_read(2'd3, r); check("baud_after_reset", r, 32'd868);
    repeat (20) @(negedge clk);
    check("txd_idle_after_reset", txd, 1);
    check("frames_after_reset", frames_done, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mio_uart_tx.md
Name: mio_uart_tx

Overview:
Memory-mapped UART transmitter peripheral that responds to CPU bus accesses decoded by the MIO bus controller.
- CPU writes bytes into a small TX FIFO.
- The block serialises them as 8N1 frames on txd.
- It exposes status and control registers and raises a level interrupt when all queued data has been sent.
- It is the bus responder for the CPU's initiator-side Addr_out/Data_out/mem_w traffic and sits beside the GPIO and counter peripherals.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the TX FIFO; power of two, 2..16.
- DEFAULT_DIV, 868, reset value of the baud divisor (100 MHz / 115200).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rstn, input, 1, asynchronous active-low reset.
- sel, input, 1, chip select from MIO bus address decode; the access targets this block this cycle.
- we, input, 1, write strobe, qualified by sel.
- addr, input, 2, word offset (CPU address bits [3:2]).
- wdata, input, 32, write data from CPU.
- rdata, output, 32, read data to CPU bus mux.
- txd, output, 1, serial output; idle high.
- irq, output, 1, level interrupt request.

Behaviour:
Interface decision: one clock (clk); reset is asynchronous and active-low (rstn).

Register map (offset = addr):
- 0 DATA:
  - Write pushes wdata[7:0] into the FIFO.
  - Read returns 0.
- 1 STATUS, read-only except bit3:
  - [0] busy: shifter active.
  - [1] full.
  - [2] empty.
  - [3] overflow: sticky; cleared by a write with wdata[3]=1.
  - [8:4] count: zero-extended; bits above are 0.
- 2 CTRL, R/W:
  - [0] en.
  - [1] irq_en.
  - Other bits read 0.
- 3 BAUD, R/W:
  - [15:0] div.
  - Upper bits read 0.

Bus rules:
- rdata is combinational from addr while sel=1, and 0 when sel=0.
- A write takes effect at the clk edge where sel & we = 1.
- A write with sel=0 is ignored.

Reset values:
- txd=1, irq=0, rdata=0 (sel low).
- FIFO empty (count=0), overflow=0.
- en=0, irq_en=0, div=DEFAULT_DIV.
- FSM in IDLE.

FIFO:
- Circular buffer with read/write pointers and a count.
- Push while full (and no pop in the same cycle): data is dropped and overflow is set.
- Push and pop in the same cycle: both occur and count is unchanged. This includes the full case; the push is accepted.

FSM states:
- IDLE:
  - txd=1.
  - If en=1 and the FIFO is not empty: pop the head byte into the shift register, latch div into the bit timer (values <2 are treated as 2), and go to START.
- START:
  - txd=0 for div cycles, then go to DATA with bit index 0.
- DATA:
  - txd = shift[idx], LSB first, each bit held div cycles.
  - After idx=7, go to STOP.
- STOP:
  - txd=1 for div cycles.
  - Then, if en=1 and the FIFO is not empty, load the next byte and go to START directly with no idle gap; otherwise go to IDLE.

Timing:
- Frame length is exactly 10*div clk cycles.
- txd falls on the first cycle after the pop edge.
- busy = 1 in START, DATA and STOP.

Boundary cases:
- Bit timer counts div-1 down to 0; 0 ends the bit.
- Writing BAUD mid-frame does not affect the current frame; it applies from the next START.
- Clearing en mid-frame: the current frame completes, then the FSM stays in IDLE; the FIFO is retained.
- irq = irq_en & empty & ~busy, registered (1 cycle after the condition).
- rstn asserted mid-frame: immediately txd=1, FIFO flushed, all registers return to reset values.

Test Plan:
- Reset then read all registers → STATUS=0x004, CTRL=0, BAUD=868, txd=1, irq=0.
- Set BAUD=4, CTRL=1, write DATA=0xA5:
  - txd low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles.
  - busy high for exactly 40 cycles.
- With en=0, write 5 bytes (DEPTH=4):
  - STATUS count=4, full=1, overflow=1.
  - Write STATUS=0x8 → overflow=0, count still 4.
- Then set CTRL=3, BAUD=2:
  - 4 back-to-back frames with no idle gap (80 cycles).
  - irq rises 1 cycle after the last stop bit ends; writing CTRL=1 drops irq.
- FIFO full, and a push coincides with the pop at frame start → count stays 4, overflow stays 0, pushed byte later transmitted in order.
- Mid-frame: write BAUD=8 then CTRL=0:
  - Current frame finishes at the old div.
  - No further frame starts.
  - Pull rstn low mid-frame → txd=1 asynchronously, count=0.
